vga_text_timing: RTL and testbench
==================================

Name: vga_text_timing

Overview:
- Pixel-rate timing and text-cell sequencer for the VGA text path.
- Generates 640x480@60 sync and blanking and walks the 80x30 text buffer in 8x16 cells.
- Reads character codes from a synchronous text RAM.
- Delivers hsync, vsync, VGA_blank, caracter, columna and fila, pipeline-aligned, to the text pixel stage that drives the DAC.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low)
TEXT_COLS, 80, character cells per text row (H_VISIBLE/8)

Ports:
clk  in  1  pixel clock (25.175 MHz), sole clock
rst_n  in  1  asynchronous active-low reset
text_data  in  8  character code from text RAM, valid the cycle after text_addr is presented
text_addr  out  12  text RAM read address = cell_row*TEXT_COLS + cell_col
hsync  out  1  horizontal sync, pipeline-aligned
vsync  out  1  vertical sync, pipeline-aligned
VGA_blank  out  1  1 = outside visible area
caracter  out  8  character code for current cell
columna  out  3  pixel x within cell (h[2:0])
fila  out  4  pixel line within cell (v[3:0])
frame_start  out  1  one-cycle pulse aligned with output pixel (0,0)

Behaviour:
- Counters:
  - h_cnt counts 0..H_TOTAL-1 (H_TOTAL = 800), 10 bits; v_cnt counts 0..V_TOTAL-1 (V_TOTAL = 525), 10 bits.
  - h_cnt wraps to 0 after H_TOTAL-1; on that cycle v_cnt increments.
  - v_cnt wraps 524 to 0 only on the cycle h_cnt = 799.
- Decode from counter values (h,v):
  - visible = (h < H_VISIBLE) && (v < V_VISIBLE).
  - hs_raw asserted for H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC, i.e. h = 656..751.
  - vs_raw asserted for V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC, i.e. v = 490..491, across the full lines.
- Pipeline: 3 stages; every output reflects the counter value from 3 cycles earlier.
  - S1 (cycle n+1):
    - text_addr <= (v>>4)*TEXT_COLS + (h>>3) when visible, else 0.
    - Multiply is implemented as shift-add: (r<<6)+(r<<4). Max value is 2399; no overflow in 12 bits.
    - Registers sync/blank/columna/fila/frame flag.
  - S2 (cycle n+2): RAM returns text_data; sync/blank/columna/fila/frame flag delayed one more stage.
  - S3 (cycle n+3):
    - caracter <= text_data if S2 visible, else 8'h00.
    - hsync, vsync, VGA_blank, columna, fila, frame_start registered from S2.
- Output drive levels:
  - hsync = SYNC_ACTIVE when hs_raw, else ~SYNC_ACTIVE; vsync likewise.
  - VGA_blank = ~visible.
- Blank-area outputs: columna and fila continue to track h[2:0]/v[3:0] during blanking. Downstream masks them via VGA_blank.
- frame_start: 1 for exactly one cycle, when the S3 stage holds (h,v) = (0,0).
- Reset, asserted asynchronously and at any time, including mid-line or mid-frame:
  - h_cnt = v_cnt = 0; all pipeline stages cleared.
  - text_addr = 0, caracter = 0, columna = 0, fila = 0, frame_start = 0.
  - VGA_blank = 1; hsync = vsync = ~SYNC_ACTIVE.
- After reset release:
  - First rising edge with rst_n = 1 advances h_cnt to 1; counter (0,0) is held during reset.
  - Output pixel (0,0) appears 3 cycles after the first edge: frame_start = 1 at that point, and it is not glitched during reset.
- Font ROM lookup and pixel selection are downstream. This block only guarantees mutual alignment of its outputs.

Test Plan:
1. Reset -> hold rst_n=0 for 5 cycles, release -> during reset VGA_blank=1, hsync=vsync=1, caracter=0, text_addr=0; frame_start pulses once 3 cycles after first edge, then not again for 420000 cycles.
2. Addressing -> RAM model returns addr[7:0]; on line v=0, h=0..7 -> text_addr=0, h=8 -> 1, h=639 -> 79; on v=16, h=0 -> 80; on v=479, h=639 -> 2399; caracter equals model data with exactly 3-cycle lag from counter value; 0x00 during blank.
3. Horizontal timing -> per line hsync low for exactly 96 cycles, starting 656 cycles after line start as seen at outputs; VGA_blank low for exactly 640 cycles per visible line; line period 800.
4. Vertical timing -> vsync low for exactly 1600 cycles starting at line 490; VGA_blank high for all of lines 480..524; frame period 420000 cycles between frame_start pulses.
5. Cell coordinates -> at output pixel (13,37): columna=5, fila=5; at (639,479): columna=7, fila=15; wrap 799->0 and 524->0 with no extra or missing cycle.
6. Mid-frame reset -> assert rst_n=0 at v=200, h=300 -> outputs return to reset values asynchronously, same cycle; after release, timing restarts from (0,0) identical to test 1.

Source files
------------

// File: rtl/vga_text_timing.sv
// 640x480@60 sync/blank generator and 80x30 text-cell sequencer. A three-stage
// pipeline keeps sync, blank, cell coordinates and the RAM character aligned.
module vga_text_timing #(
  parameter int   H_VISIBLE   = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_VISIBLE   = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter logic SYNC_ACTIVE = 1'b0,
  parameter int   TEXT_COLS   = 80
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  text_data,
  output logic [11:0] text_addr,
  output logic        hsync,
  output logic        vsync,
  output logic        VGA_blank,
  output logic [7:0]  caracter,
  output logic [2:0]  columna,
  output logic [3:0]  fila,
  output logic        frame_start
);

  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  // Per-pixel attributes carried down the pipeline; sync flags stay raw
  // (1 = in pulse) and are converted to drive level only at the pins.
  typedef struct packed {
    logic       vis;
    logic       hs;
    logic       vs;
    logic       frame;
    logic [2:0] col;
    logic [3:0] row;
  } stage_t;

  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  stage_t      s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [11:0] text_addr_q, text_addr_d;
  logic [7:0]  caracter_q, caracter_d;
  logic [11:0] cell_addr;
  logic        visible;

  logic [5:0] cell_row;
  logic [6:0] cell_col;
  assign cell_row = v_cnt_q[9:4];
  assign cell_col = h_cnt_q[9:3];

  generate
    if (TEXT_COLS == 80) begin : g_mul80
      assign cell_addr = {cell_row, 6'b0} + {2'b0, cell_row, 4'b0} + {5'b0, cell_col};
    end else begin : g_mul_generic
      assign cell_addr = 12'(cell_row * TEXT_COLS) + {5'b0, cell_col};
    end
  endgenerate

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
    end

    visible     = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    s1_d.vis    = visible;
    s1_d.hs     = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
    s1_d.vs     = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
    s1_d.frame  = (h_cnt_q == '0) && (v_cnt_q == '0);
    s1_d.col    = h_cnt_q[2:0];
    s1_d.row    = v_cnt_q[3:0];
    text_addr_d = visible ? cell_addr : '0;

    s2_d        = s1_q;
    s3_d        = s2_q;
    caracter_d  = s2_q.vis ? text_data : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      text_addr_q <= '0;
      caracter_q  <= '0;
    end else begin
      // NOTE: non-blocking so all stages sample pre-edge values and shift together.
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      text_addr_q <= text_addr_d;
      caracter_q  <= caracter_d;
    end
  end

  // A cleared S3 stage reads as blank with both syncs idle.
  assign text_addr   = text_addr_q;
  assign caracter    = caracter_q;
  assign hsync       = s3_q.hs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vsync       = s3_q.vs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign VGA_blank   = ~s3_q.vis;
  assign columna     = s3_q.col;
  assign fila        = s3_q.row;
  assign frame_start = s3_q.frame;

endmodule

// File: tb/tb_vga_text_timing.sv
// Directed bench for vga_text_timing; the vertical timing is shortened
// (32 visible lines, 41 total) so full frames fit in a short run.
module tb_vga_text_timing;

  localparam int HT    = 800;
  localparam int VV    = 32;
  localparam int VF    = 4;
  localparam int VS    = 2;
  localparam int VB    = 3;
  localparam int VT    = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  text_data = 8'h00;
  logic [11:0] text_addr;
  logic        hsync, vsync, VGA_blank, frame_start;
  logic [7:0]  caracter;
  logic [2:0]  columna;
  logic [3:0]  fila;

  int tests_run = 0;
  int failed    = 0;
  int e         = 0;  // rising edges since reset release

  vga_text_timing #(
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .text_data(text_data), .text_addr(text_addr),
    .hsync(hsync), .vsync(vsync), .VGA_blank(VGA_blank), .caracter(caracter),
    .columna(columna), .fila(fila), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Synchronous text RAM whose contents equal the low address byte.
  always @(posedge clk) text_data <= text_addr[7:0];

  task automatic tick();
    @(posedge clk);
    e++;
    #1;
  endtask

  task automatic goto(input int target);
    while (e < target) tick();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    e = 0;
  endtask

  task automatic check_reset_values(input string tag);
    tests_run++;
    if ({VGA_blank, hsync, vsync, frame_start} !== 4'b1110 || caracter !== 8'h00 ||
        text_addr !== 12'h000 || columna !== 3'd0 || fila !== 4'd0) begin
      failed++;
      $display("FAIL %s: blank=%b hs=%b vs=%b fs=%b car=%h addr=%h col=%0d fila=%0d, required 1 1 1 0 00 000 0 0",
               tag, VGA_blank, hsync, vsync, frame_start, caracter, text_addr, columna, fila);
    end
  endtask

  task automatic check_first_frame_start(input string tag);
    for (int i = 1; i <= 4; i++) begin
      tick();
      tests_run++;
      if (frame_start !== (e == 3)) begin
        failed++;
        $display("FAIL %s_fs_e%0d: got %b required %b", tag, e, frame_start, (e == 3));
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_reset_values("reset_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;
    e = 0;
    check_first_frame_start("reset");
  endtask

  task automatic test_addressing();
    do_reset(2);
    for (int t = 1; t <= 8; t++) begin
      goto(t);
      tests_run++;
      if (text_addr !== 12'd0) begin failed++; $display("FAIL addr_h%0d: got %0d required 0", t - 1, text_addr); end
    end
    goto(9);
    tests_run++;
    if (text_addr !== 12'd1) begin failed++; $display("FAIL addr_h8: got %0d required 1", text_addr); end
    goto(10);
    tests_run++;
    if (caracter !== 8'h00) begin failed++; $display("FAIL car_h7: got %h required 00", caracter); end
    goto(11);
    tests_run++;
    if (caracter !== 8'h01) begin failed++; $display("FAIL car_h8: got %h required 01", caracter); end
    goto(640);
    tests_run++;
    if (text_addr !== 12'd79) begin failed++; $display("FAIL addr_h639: got %0d required 79", text_addr); end
    goto(641);
    tests_run++;
    if (text_addr !== 12'd0) begin failed++; $display("FAIL addr_h640_blank: got %0d required 0", text_addr); end
    goto(642);
    tests_run++;
    if (caracter !== 8'h4F) begin failed++; $display("FAIL car_h639: got %h required 4f", caracter); end
    goto(643);
    tests_run++;
    if (caracter !== 8'h00) begin failed++; $display("FAIL car_h640_blank: got %h required 00", caracter); end
    goto(16 * HT + 1);
    tests_run++;
    if (text_addr !== 12'd80) begin failed++; $display("FAIL addr_v16: got %0d required 80", text_addr); end
    goto(16 * HT + 3);
    tests_run++;
    if (caracter !== 8'h50) begin failed++; $display("FAIL car_v16: got %h required 50", caracter); end
  endtask

  task automatic test_cells();
    goto(21 * HT + 13 + 3);
    tests_run++;
    if (columna !== 3'd5 || fila !== 4'd5 || VGA_blank !== 1'b0) begin
      failed++; $display("FAIL cell_13_21: col=%0d fila=%0d blank=%b required 5 5 0", columna, fila, VGA_blank);
    end
    goto(31 * HT + 640);
    tests_run++;
    if (text_addr !== 12'd159) begin failed++; $display("FAIL addr_last: got %0d required 159", text_addr); end
    goto(31 * HT + 639 + 3);
    tests_run++;
    if (columna !== 3'd7 || fila !== 4'd15 || caracter !== 8'h9F || VGA_blank !== 1'b0) begin
      failed++; $display("FAIL cell_last: col=%0d fila=%0d car=%h blank=%b required 7 15 9f 0", columna, fila, caracter, VGA_blank);
    end
    goto(31 * HT + 799 + 3);
    tests_run++;
    if (columna !== 3'd7 || fila !== 4'd15 || VGA_blank !== 1'b1 || caracter !== 8'h00) begin
      failed++; $display("FAIL cell_h799: col=%0d fila=%0d blank=%b car=%h required 7 15 1 00", columna, fila, VGA_blank, caracter);
    end
    tick();
    tests_run++;
    if (columna !== 3'd0 || fila !== 4'd0 || VGA_blank !== 1'b1) begin
      failed++; $display("FAIL cell_wrap_v32: col=%0d fila=%0d blank=%b required 0 0 1", columna, fila, VGA_blank);
    end
  endtask

  task automatic test_horizontal();
    int hs_low = 0, hs_first = -1, hs_first2 = -1, bl_low = 0;
    do_reset(2);
    while (e < 2 * HT + 3) begin
      tick();
      if (e >= 3 && e < HT + 3) begin
        if (!hsync) begin hs_low++; if (hs_first < 0) hs_first = e; end
        if (!VGA_blank) bl_low++;
      end else if (e >= HT + 3 && !hsync && hs_first2 < 0) hs_first2 = e;
      if (e == HT + 2) begin
        tests_run++;
        if (columna !== 3'd7 || fila !== 4'd0) begin failed++; $display("FAIL hwrap_799: col=%0d fila=%0d required 7 0", columna, fila); end
      end
      if (e == HT + 3) begin
        tests_run++;
        if (columna !== 3'd0 || fila !== 4'd1) begin failed++; $display("FAIL hwrap_0: col=%0d fila=%0d required 0 1", columna, fila); end
      end
    end
    tests_run++;
    if (hs_low !== 96) begin failed++; $display("FAIL hsync_width: got %0d required 96", hs_low); end
    tests_run++;
    if (hs_first !== 656 + 3) begin failed++; $display("FAIL hsync_start: got e=%0d required %0d", hs_first, 656 + 3); end
    tests_run++;
    if (bl_low !== 640) begin failed++; $display("FAIL blank_active: got %0d required 640", bl_low); end
    tests_run++;
    if (hs_first2 - hs_first !== HT) begin failed++; $display("FAIL line_period: got %0d required %0d", hs_first2 - hs_first, HT); end
  endtask

  task automatic test_vertical();
    int vs_low = 0, vs_first = -1, bl_low = 0, bad_blank = 0, fs_cnt = 0, fs_last = -1;
    do_reset(2);
    while (e < FRAME + 4) begin
      tick();
      if (e >= 3 && e < FRAME + 3) begin
        if (!vsync) begin vs_low++; if (vs_first < 0) vs_first = e; end
        if (!VGA_blank) begin bl_low++; if ((e - 3) / HT >= VV) bad_blank++; end
      end
      if (frame_start) begin fs_cnt++; fs_last = e; end
    end
    tests_run++;
    if (vs_first !== (VV + VF) * HT + 3) begin failed++; $display("FAIL vsync_start: got e=%0d required %0d", vs_first, (VV + VF) * HT + 3); end
    tests_run++;
    if (vs_low !== VS * HT) begin failed++; $display("FAIL vsync_width: got %0d required %0d", vs_low, VS * HT); end
    tests_run++;
    if (bl_low !== VV * 640) begin failed++; $display("FAIL blank_frame: got %0d required %0d", bl_low, VV * 640); end
    tests_run++;
    if (bad_blank !== 0) begin failed++; $display("FAIL blank_vporch: got %0d unblanked pixels required 0", bad_blank); end
    tests_run++;
    if (fs_cnt !== 2 || fs_last !== FRAME + 3) begin
      failed++; $display("FAIL frame_period: got %0d pulses last e=%0d required 2 at %0d", fs_cnt, fs_last, FRAME + 3);
    end
  endtask

  task automatic test_midframe_reset();
    do_reset(2);
    goto(20 * HT + 300);
    tests_run++;
    if (text_addr !== 12'd117 || caracter !== 8'h75 || columna !== 3'd1 || fila !== 4'd4 || VGA_blank !== 1'b0) begin
      failed++; $display("FAIL mid_pre: addr=%0d car=%h col=%0d fila=%0d blank=%b required 117 75 1 4 0",
                         text_addr, caracter, columna, fila, VGA_blank);
    end
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_async");
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("mid_hold");
    @(negedge clk);
    rst_n = 1'b1;
    e = 0;
    check_first_frame_start("mid");
    goto(9);
    tests_run++;
    if (text_addr !== 12'd1) begin failed++; $display("FAIL mid_addr_h8: got %0d required 1", text_addr); end
  endtask

  initial begin
    test_reset();
    test_addressing();
    test_cells();
    test_horizontal();
    test_vertical();
    test_midframe_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
